// File: rtl/dcache_mem_ctrl_if.sv
// dcache_mem_ctrl_if: request, memory-bus and fill/feedback signals of the
// dcache miss controller. The master modport is the dcache/LSQ plus memory
// side (stimulus), and the slave modport is the controller itself.
interface dcache_mem_ctrl_if #(
    parameter int LSQSZ    = 16,
    parameter int ADDR_W   = 16,
    parameter int IDX_W    = 5,
    parameter int Q_DEPTH  = 8,
    parameter int NUM_MSHR = 4
) ();
    logic                           except;
    logic                           wb_valid, wb_ready;
    logic [ADDR_W-1:0]              wb_addr;
    logic [63:0]                    wb_data;
    logic                           wr_valid, wr_ready;
    logic [ADDR_W-1:0]              wr_addr;
    logic [63:0]                    wr_data;
    logic [1:0]                     wr_size;
    logic                           rd_valid, rd_ready;
    logic [ADDR_W-1:0]              rd_addr;
    logic [1:0]                     rd_size;
    logic                           rd_signed;
    logic [LSQSZ-1:0]               rd_gnt;
    logic [3:0]                     mem2proc_response;
    logic [63:0]                    mem2proc_data;
    logic [3:0]                     mem2proc_tag;
    logic [1:0]                     Dmem_command;
    logic [ADDR_W-1:0]              Dmem_addr;
    logic [1:0]                     Dmem_size;
    logic [63:0]                    Dmem_data;
    logic [LSQSZ-1:0]               mem_feedback;
    logic [31:0]                    mem_data;
    logic                           mem_wr_en;
    logic [IDX_W-1:0]               mem_wr_idx;
    logic [ADDR_W-IDX_W-4:0]        mem_wr_tag;
    logic [63:0]                    mem_wr_data;
    logic [$clog2(Q_DEPTH):0]       q_count;
    logic [NUM_MSHR-1:0]            mshr_busy;

    modport master (
        output except, wb_valid, wb_addr, wb_data, wr_valid, wr_addr, wr_data, wr_size,
               rd_valid, rd_addr, rd_size, rd_signed, rd_gnt,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  wb_ready, wr_ready, rd_ready, Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
               mem_feedback, mem_data, mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
               q_count, mshr_busy
    );

    modport slave (
        input  except, wb_valid, wb_addr, wb_data, wr_valid, wr_addr, wr_data, wr_size,
               rd_valid, rd_addr, rd_size, rd_signed, rd_gnt,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output wb_ready, wr_ready, rd_ready, Dmem_command, Dmem_addr, Dmem_size, Dmem_data,
               mem_feedback, mem_data, mem_wr_en, mem_wr_idx, mem_wr_tag, mem_wr_data,
               q_count, mshr_busy
    );
endinterface

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: in-order request FIFO (writeback, write-miss, read-miss)
// feeding the memory bus one entry per cycle, plus an MSHR file that matches
// out-of-order load completions by memory tag. An exception squashes queued
// and outstanding loads without losing the dcache fill.
// Optional feature macro: DCACHE_MEM_CTRL_SIGNEXT_EN (sign-extend BYTE/HALF
// load results when the request was marked signed).
module dcache_mem_ctrl #(
    parameter int LSQSZ    = 16,
    parameter int ADDR_W   = 16,
    parameter int IDX_W    = 5,
    parameter int Q_DEPTH  = 8,
    parameter int NUM_MSHR = 4
) (
    input  logic               clock,
    input  logic               reset,
    dcache_mem_ctrl_if.slave   bus
);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MID_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2} bus_cmd_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_DOUBLE = 2'd3} size_e;
    typedef enum logic [1:0] {K_NOP = 2'd0, K_STORE = 2'd1, K_LOAD = 2'd2} kind_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
        logic [1:0]        size;
        logic              sgn;
        logic [LSQSZ-1:0]  gnt;
    } req_t;

    // FIFO state
    req_t              fifo_q [Q_DEPTH];
    kind_e             kind_q [Q_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  q_count_q, q_count_d, free_slots;
    logic [PTR_W-1:0]  slot_wb, slot_wr, slot_rd;
    logic              wb_ready, wr_ready, rd_ready, wb_fire, wr_fire, rd_fire;

    // Head / issue
    req_t              head;
    kind_e             head_kind;
    logic              head_valid, pop, alloc;
    bus_cmd_e          dmem_cmd;
    logic [ADDR_W-1:0] dmem_addr;
    logic [1:0]        dmem_size;
    logic [63:0]       dmem_data;

    // MSHR file
    logic [NUM_MSHR-1:0] mshr_valid_q, mshr_sq_q;
    logic [ADDR_W-1:0]   mshr_addr_q [NUM_MSHR];
    logic [1:0]          mshr_size_q [NUM_MSHR];
    logic                mshr_sgn_q  [NUM_MSHR];
    logic [LSQSZ-1:0]    mshr_gnt_q  [NUM_MSHR];
    logic [3:0]          mshr_tag_q  [NUM_MSHR];
    logic [MID_W-1:0]    alloc_idx, hit_idx;
    logic                mshr_free_any, hit;
    logic [ADDR_W-1:0]   hit_addr;
    logic [31:0]         shifted, result;

    // Readiness comes only from registered occupancy, never from this cycle's pop.
    assign free_slots = CNT_W'(Q_DEPTH) - q_count_q;
    assign wb_ready   = free_slots >= CNT_W'(1);
    assign wr_ready   = free_slots >= (CNT_W'(1) + CNT_W'(bus.wb_valid));
    assign rd_ready   = free_slots >= (CNT_W'(1) + CNT_W'(bus.wb_valid) + CNT_W'(bus.wr_valid));
    assign wb_fire    = bus.wb_valid & wb_ready;
    assign wr_fire    = bus.wr_valid & wr_ready;
    assign rd_fire    = bus.rd_valid & rd_ready;
    assign slot_wb    = wr_ptr_q;
    assign slot_wr    = slot_wb + PTR_W'(wb_fire);
    assign slot_rd    = slot_wr + PTR_W'(wr_fire);
    assign wr_ptr_d   = slot_rd + PTR_W'(rd_fire);
    assign rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    assign q_count_d  = q_count_q + CNT_W'(wb_fire) + CNT_W'(wr_fire) + CNT_W'(rd_fire) - CNT_W'(pop);

    assign head       = fifo_q[rd_ptr_q];
    assign head_kind  = kind_q[rd_ptr_q];
    assign head_valid = (q_count_q != '0);

    // Lowest free MSHR, from registered valid bits only.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        alloc_idx     = '0;
        mshr_free_any = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!mshr_valid_q[i]) begin
                alloc_idx     = MID_W'(i);
                mshr_free_any = 1'b1;
            end
        end
    end

    // Present the FIFO head on the bus; squashed loads drain without a command.
    always_comb begin
        dmem_cmd  = BUS_NONE;
        dmem_addr = '0;
        dmem_size = '0;
        dmem_data = '0;
        pop       = 1'b0;
        if (head_valid) begin
            case (head_kind)
                K_STORE: begin
                    dmem_cmd  = BUS_STORE;
                    dmem_addr = head.addr;
                    dmem_size = head.size;
                    dmem_data = head.data;
                    pop       = (bus.mem2proc_response != 4'd0);
                end
                K_LOAD: begin
                    if (mshr_free_any) begin
                        dmem_cmd  = BUS_LOAD;
                        dmem_addr = head.addr;
                        dmem_size = SZ_DOUBLE;
                        pop       = (bus.mem2proc_response != 4'd0);
                    end
                end
                default: pop = 1'b1;
            endcase
        end
    end

    assign alloc = pop && (head_kind == K_LOAD);

    // Match a completing memory tag against the valid MSHRs.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (mshr_valid_q[i] && (bus.mem2proc_tag != 4'd0) && (mshr_tag_q[i] == bus.mem2proc_tag)) begin
                hit     = 1'b1;
                hit_idx = MID_W'(i);
            end
        end
    end

    assign hit_addr = mshr_addr_q[hit_idx];
    assign shifted  = 32'(bus.mem2proc_data >> {hit_addr[2:0], 3'b000});

    // Extract the requested bytes of the returned doubleword.
    always_comb begin
        case (mshr_size_q[hit_idx])
            SZ_BYTE: result = {24'b0, shifted[7:0]};
            SZ_HALF: result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
`ifdef DCACHE_MEM_CTRL_SIGNEXT_EN
        if (mshr_sgn_q[hit_idx]) begin
            case (mshr_size_q[hit_idx])
                SZ_BYTE: result = {{24{shifted[7]}}, shifted[7:0]};
                SZ_HALF: result = {{16{shifted[15]}}, shifted[15:0]};
                default: result = shifted;
            endcase
        end
`endif
    end

`ifndef DCACHE_MEM_CTRL_SIGNEXT_EN
    logic unused_sgn;
    assign unused_sgn = ^{mshr_sgn_q};
`endif

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            q_count_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            q_count_q <= q_count_d;
        end
    end

    // FIFO payload and entry kind; except turns every queued load into a no-op.
    always_ff @(posedge clock) begin
        // NOTE: storage arrays are not reset; q_count and the pointers define which entries are live.
        if (bus.except) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                if (kind_q[i] == K_LOAD) kind_q[i] <= K_NOP;
            end
        end
        if (wb_fire) begin
            fifo_q[slot_wb] <= '{addr: bus.wb_addr, data: bus.wb_data, size: SZ_DOUBLE, sgn: 1'b0, gnt: '0};
            kind_q[slot_wb] <= K_STORE;
        end
        if (wr_fire) begin
            fifo_q[slot_wr] <= '{addr: bus.wr_addr, data: bus.wr_data, size: bus.wr_size, sgn: 1'b0, gnt: '0};
            kind_q[slot_wr] <= K_STORE;
        end
        if (rd_fire) begin
            fifo_q[slot_rd] <= '{addr: bus.rd_addr, data: '0, size: bus.rd_size, sgn: bus.rd_signed, gnt: bus.rd_gnt};
            kind_q[slot_rd] <= bus.except ? K_NOP : K_LOAD;
        end
    end

    // MSHR valid/squash bits: free on completion, squash on except, allocate on load pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mshr_valid_q <= '0;
            mshr_sq_q    <= '0;
        end else begin
            if (hit) mshr_valid_q[hit_idx] <= 1'b0;
            if (bus.except) mshr_sq_q <= mshr_sq_q | mshr_valid_q;
            if (alloc) begin
                mshr_valid_q[alloc_idx] <= 1'b1;
                mshr_sq_q[alloc_idx]    <= bus.except;
            end
        end
    end

    // MSHR payload captured at allocation.
    always_ff @(posedge clock) begin
        if (alloc) begin
            mshr_addr_q[alloc_idx] <= head.addr;
            mshr_size_q[alloc_idx] <= head.size;
            mshr_sgn_q[alloc_idx]  <= head.sgn;
            mshr_gnt_q[alloc_idx]  <= head.gnt;
            mshr_tag_q[alloc_idx]  <= bus.mem2proc_response;
        end
    end

    assign bus.wb_ready     = wb_ready;
    assign bus.wr_ready     = wr_ready;
    assign bus.rd_ready     = rd_ready;
    assign bus.Dmem_command = dmem_cmd;
    assign bus.Dmem_addr    = dmem_addr;
    assign bus.Dmem_size    = dmem_size;
    assign bus.Dmem_data    = dmem_data;
    assign bus.mem_wr_en    = hit;
    assign bus.mem_wr_data  = bus.mem2proc_data;
    assign bus.mem_wr_idx   = hit ? hit_addr[IDX_W+2:3] : '0;
    assign bus.mem_wr_tag   = hit ? hit_addr[ADDR_W-1:IDX_W+3] : '0;
    assign bus.mem_feedback = (hit && !mshr_sq_q[hit_idx]) ? mshr_gnt_q[hit_idx] : '0;
    assign bus.mem_data     = (hit && !mshr_sq_q[hit_idx]) ? result : '0;
    assign bus.q_count      = q_count_q;
    assign bus.mshr_busy    = mshr_valid_q;
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: directed bench for dcache_mem_ctrl. Inputs change 1 time
// unit after the rising edge; outputs are sampled 1 unit later.
module tb_dcache_mem_ctrl;
    localparam int LSQSZ = 16, ADDR_W = 16, IDX_W = 5, Q_DEPTH = 8, NUM_MSHR = 4;
    localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_DOUBLE = 2'd3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0]  dr_tag [4] = '{4'd1, 4'd3, 4'd4, 4'd9};
    logic [15:0] dr_fb  [4] = '{16'h0001, 16'h0004, 16'h0008, 16'h0010};

    dcache_mem_ctrl_if #(.LSQSZ(LSQSZ), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                         .Q_DEPTH(Q_DEPTH), .NUM_MSHR(NUM_MSHR)) bus_if ();

    dcache_mem_ctrl #(.LSQSZ(LSQSZ), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                      .Q_DEPTH(Q_DEPTH), .NUM_MSHR(NUM_MSHR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus_if.except = 1'b0;
        bus_if.wb_valid = 1'b0; bus_if.wb_addr = '0; bus_if.wb_data = '0;
        bus_if.wr_valid = 1'b0; bus_if.wr_addr = '0; bus_if.wr_data = '0; bus_if.wr_size = '0;
        bus_if.rd_valid = 1'b0; bus_if.rd_addr = '0; bus_if.rd_size = '0;
        bus_if.rd_signed = 1'b0; bus_if.rd_gnt = '0;
        bus_if.mem2proc_response = '0; bus_if.mem2proc_data = '0; bus_if.mem2proc_tag = '0;
    endtask

    task automatic push_rd(input logic [15:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [15:0] gnt);
        bus_if.rd_valid = 1'b1; bus_if.rd_addr = addr; bus_if.rd_size = size;
        bus_if.rd_signed = sgn; bus_if.rd_gnt = gnt;
    endtask

    initial begin
        idle();
        tick(); tick();

        // ---- reset state ----
        reset = 1'b1;
        settle();
        check("rst q_count", bus_if.q_count, 0);
        check("rst mshr_busy", bus_if.mshr_busy, 0);
        check("rst cmd", bus_if.Dmem_command, BUS_NONE);
        check("rst addr", bus_if.Dmem_addr, 0);
        check("rst size", bus_if.Dmem_size, 0);
        check("rst data", bus_if.Dmem_data, 0);
        check("rst feedback", bus_if.mem_feedback, 0);
        check("rst mem_data", bus_if.mem_data, 0);
        check("rst wr_en", bus_if.mem_wr_en, 0);
        check("rst readys", {bus_if.wb_ready, bus_if.wr_ready, bus_if.rd_ready}, 3'b111);

        // ---- wb + wr + rd in one cycle, issued in order ----
        bus_if.wb_valid = 1'b1; bus_if.wb_addr = 16'h0100; bus_if.wb_data = 64'hA5A5_0000_0000_5A5A;
        bus_if.wr_valid = 1'b1; bus_if.wr_addr = 16'h0208; bus_if.wr_data = 64'hBEEF; bus_if.wr_size = SZ_HALF;
        push_rd(16'h0310, SZ_WORD, 1'b0, 16'h0004);
        settle();
        check("t1 readys", {bus_if.wb_ready, bus_if.wr_ready, bus_if.rd_ready}, 3'b111);
        tick(); idle();
        bus_if.mem2proc_response = 4'd1; settle();
        check("t1 q3", bus_if.q_count, 3);
        check("t1 wb cmd", bus_if.Dmem_command, BUS_STORE);
        check("t1 wb addr", bus_if.Dmem_addr, 16'h0100);
        check("t1 wb size", bus_if.Dmem_size, SZ_DOUBLE);
        check("t1 wb data", bus_if.Dmem_data, 64'hA5A5_0000_0000_5A5A);
        tick(); bus_if.mem2proc_response = 4'd2; settle();
        check("t1 q2", bus_if.q_count, 2);
        check("t1 wr cmd", bus_if.Dmem_command, BUS_STORE);
        check("t1 wr addr", bus_if.Dmem_addr, 16'h0208);
        check("t1 wr size", bus_if.Dmem_size, SZ_HALF);
        check("t1 wr data", bus_if.Dmem_data, 64'hBEEF);
        tick(); bus_if.mem2proc_response = 4'd3; settle();
        check("t1 q1", bus_if.q_count, 1);
        check("t1 rd cmd", bus_if.Dmem_command, BUS_LOAD);
        check("t1 rd addr", bus_if.Dmem_addr, 16'h0310);
        check("t1 rd size", bus_if.Dmem_size, SZ_DOUBLE);
        check("t1 rd data", bus_if.Dmem_data, 0);
        tick(); bus_if.mem2proc_response = 4'd0; settle();
        check("t1 q0", bus_if.q_count, 0);
        check("t1 busy", bus_if.mshr_busy, 4'b0001);
        check("t1 idle cmd", bus_if.Dmem_command, BUS_NONE);
        bus_if.mem2proc_tag = 4'd3; bus_if.mem2proc_data = 64'h1122_3344_5566_7788; settle();
        check("t1 wr_en", bus_if.mem_wr_en, 1);
        check("t1 feedback", bus_if.mem_feedback, 16'h0004);
        check("t1 mem_data", bus_if.mem_data, 32'h5566_7788);
        check("t1 fill idx", bus_if.mem_wr_idx, 5'd2);
        check("t1 fill tag", bus_if.mem_wr_tag, 8'h03);
        check("t1 fill data", bus_if.mem_wr_data, 64'h1122_3344_5566_7788);
        tick(); idle(); settle();
        check("t1 freed", bus_if.mshr_busy, 0);
        check("t1 no fill", bus_if.mem_wr_en, 0);

        // ---- two outstanding loads, returned out of order ----
        push_rd(16'h0428, SZ_DOUBLE, 1'b0, 16'h0001);
        tick();
        push_rd(16'h0530, SZ_DOUBLE, 1'b0, 16'h0002);
        bus_if.mem2proc_response = 4'd5; settle();
        check("t2 A addr", bus_if.Dmem_addr, 16'h0428);
        tick(); idle();
        bus_if.mem2proc_response = 4'd6; settle();
        check("t2 B cmd", bus_if.Dmem_command, BUS_LOAD);
        check("t2 B addr", bus_if.Dmem_addr, 16'h0530);
        check("t2 busy A", bus_if.mshr_busy, 4'b0001);
        tick(); idle();
        bus_if.mem2proc_tag = 4'd6; bus_if.mem2proc_data = 64'h0123_4567_89AB_CDEF; settle();
        check("t2 busy AB", bus_if.mshr_busy, 4'b0011);
        check("t2 B feedback", bus_if.mem_feedback, 16'h0002);
        check("t2 B idx", bus_if.mem_wr_idx, 5'd6);
        check("t2 B tag", bus_if.mem_wr_tag, 8'h05);
        check("t2 B data", bus_if.mem_data, 32'h89AB_CDEF);
        tick(); bus_if.mem2proc_tag = 4'd5; settle();
        check("t2 busy A only", bus_if.mshr_busy, 4'b0001);
        check("t2 A feedback", bus_if.mem_feedback, 16'h0001);
        check("t2 A idx", bus_if.mem_wr_idx, 5'd5);
        check("t2 A tag", bus_if.mem_wr_tag, 8'h04);
        tick(); idle(); settle();
        check("t2 freed", bus_if.mshr_busy, 0);

        // ---- MSHRs full: fifth load stalls until a completion ----
        for (int i = 0; i < 5; i++) begin
            push_rd(16'h0600 + 16'(8 * i), SZ_DOUBLE, 1'b0, 16'(1 << i));
            tick();
        end
        idle(); settle();
        check("t3 q5", bus_if.q_count, 5);
        for (int i = 0; i < 4; i++) begin
            bus_if.mem2proc_response = 4'(i + 1); settle();
            check("t3 issue addr", bus_if.Dmem_addr, 16'h0600 + 16'(8 * i));
            tick();
        end
        bus_if.mem2proc_response = 4'd7; settle();
        check("t3 busy full", bus_if.mshr_busy, 4'b1111);
        check("t3 stall cmd", bus_if.Dmem_command, BUS_NONE);
        check("t3 q1", bus_if.q_count, 1);
        tick(); bus_if.mem2proc_response = 4'd0; settle();
        check("t3 held", bus_if.q_count, 1);
        bus_if.mem2proc_tag = 4'd2; settle();
        check("t3 free fb", bus_if.mem_feedback, 16'h0002);
        check("t3 still stalled", bus_if.Dmem_command, BUS_NONE);
        tick(); bus_if.mem2proc_tag = 4'd0; settle();
        check("t3 busy after free", bus_if.mshr_busy, 4'b1101);
        check("t3 late cmd", bus_if.Dmem_command, BUS_LOAD);
        check("t3 late addr", bus_if.Dmem_addr, 16'h0620);
        bus_if.mem2proc_response = 4'd9;
        tick(); bus_if.mem2proc_response = 4'd0; settle();
        check("t3 refilled", bus_if.mshr_busy, 4'b1111);
        check("t3 q0", bus_if.q_count, 0);
        for (int i = 0; i < 4; i++) begin
            bus_if.mem2proc_tag = dr_tag[i]; settle();
            check("t3 drain fb", bus_if.mem_feedback, dr_fb[i]);
            tick();
        end
        idle(); settle();
        check("t3 drained", bus_if.mshr_busy, 0);

        // ---- FIFO full and backpressure ----
        for (int k = 0; k < 4; k++) begin
            bus_if.wb_valid = 1'b1; bus_if.wb_addr = 16'h1000 + 16'(16 * k); bus_if.wb_data = 64'(k);
            bus_if.wr_valid = 1'b1; bus_if.wr_addr = 16'h2000 + 16'(16 * k);
            bus_if.wr_data = 64'(k + 256); bus_if.wr_size = SZ_WORD;
            tick();
        end
        idle(); settle();
        check("t4 q8", bus_if.q_count, 8);
        check("t4 readys full", {bus_if.wb_ready, bus_if.wr_ready, bus_if.rd_ready}, 3'b000);
        check("t4 head", bus_if.Dmem_addr, 16'h1000);
        bus_if.mem2proc_response = 4'd1;
        tick(); idle();
        bus_if.wb_valid = 1'b1; bus_if.wb_addr = 16'h3000;
        bus_if.wr_valid = 1'b1; bus_if.wr_addr = 16'h3008; settle();
        check("t4 q7", bus_if.q_count, 7);
        check("t4 readys one free", {bus_if.wb_ready, bus_if.wr_ready, bus_if.rd_ready}, 3'b100);
        tick(); idle();
        for (int c = 0; c < 3; c++) begin
            settle();
            check("t4 hold count", bus_if.q_count, 8);
            check("t4 hold head", bus_if.Dmem_addr, 16'h2000);
            check("t4 hold size", bus_if.Dmem_size, SZ_WORD);
            tick();
        end
        bus_if.mem2proc_response = 4'd1;
        for (int c = 0; c < 8; c++) tick();
        bus_if.mem2proc_response = 4'd0; settle();
        check("t4 emptied", bus_if.q_count, 0);
        check("t4 empty cmd", bus_if.Dmem_command, BUS_NONE);

        // ---- except squashes queued and outstanding loads ----
        push_rd(16'h0700, SZ_DOUBLE, 1'b0, 16'h0008);
        tick(); idle();
        bus_if.mem2proc_response = 4'd4; settle();
        check("t5 L0 cmd", bus_if.Dmem_command, BUS_LOAD);
        tick(); idle();
        push_rd(16'h0708, SZ_DOUBLE, 1'b0, 16'h0010);
        tick();
        push_rd(16'h0710, SZ_DOUBLE, 1'b0, 16'h0020);
        tick(); idle(); settle();
        check("t5 q2", bus_if.q_count, 2);
        check("t5 busy", bus_if.mshr_busy, 4'b0001);
        bus_if.except = 1'b1;
        bus_if.wr_valid = 1'b1; bus_if.wr_addr = 16'h0800; bus_if.wr_data = 64'h55; bus_if.wr_size = SZ_BYTE;
        tick(); idle(); settle();
        check("t5 q3", bus_if.q_count, 3);
        check("t5 nop1 cmd", bus_if.Dmem_command, BUS_NONE);
        tick(); settle();
        check("t5 q2 after nop", bus_if.q_count, 2);
        check("t5 nop2 cmd", bus_if.Dmem_command, BUS_NONE);
        tick(); settle();
        check("t5 q1 store", bus_if.q_count, 1);
        check("t5 store cmd", bus_if.Dmem_command, BUS_STORE);
        check("t5 store addr", bus_if.Dmem_addr, 16'h0800);
        check("t5 store size", bus_if.Dmem_size, SZ_BYTE);
        bus_if.mem2proc_response = 4'd1;
        tick(); bus_if.mem2proc_response = 4'd0; settle();
        check("t5 q0", bus_if.q_count, 0);
        bus_if.mem2proc_tag = 4'd4; bus_if.mem2proc_data = 64'h1122_3344_5566_7788; settle();
        check("t5 sq wr_en", bus_if.mem_wr_en, 1);
        check("t5 sq feedback", bus_if.mem_feedback, 0);
        check("t5 sq mem_data", bus_if.mem_data, 0);
        check("t5 sq idx", bus_if.mem_wr_idx, 5'd0);
        check("t5 sq tag", bus_if.mem_wr_tag, 8'h07);
        tick(); idle(); settle();
        check("t5 freed", bus_if.mshr_busy, 0);

        // ---- sub-word extraction ----
        push_rd(16'h0406, SZ_HALF, 1'b1, 16'h0040);
        tick(); idle();
        bus_if.mem2proc_response = 4'd10; settle();
        check("t6 half issue", bus_if.Dmem_addr, 16'h0406);
        tick(); idle();
        bus_if.mem2proc_tag = 4'd10; bus_if.mem2proc_data = 64'h8001_0000_0000_0000; settle();
`ifdef DCACHE_MEM_CTRL_SIGNEXT_EN
        check("t6 half data", bus_if.mem_data, 32'hFFFF_8001);
`else
        check("t6 half data", bus_if.mem_data, 32'h0000_8001);
`endif
        check("t6 half fb", bus_if.mem_feedback, 16'h0040);
        tick(); idle();
        push_rd(16'h0403, SZ_BYTE, 1'b0, 16'h0080);
        tick(); idle();
        bus_if.mem2proc_response = 4'd11;
        tick(); idle();
        bus_if.mem2proc_tag = 4'd11; bus_if.mem2proc_data = 64'h0000_0000_8000_0000; settle();
        check("t6 byte data", bus_if.mem_data, 32'h0000_0080);
        check("t6 byte fb", bus_if.mem_feedback, 16'h0080);
        tick(); idle(); settle();
        check("end busy", bus_if.mshr_busy, 0);
        check("end q_count", bus_if.q_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_mem_ctrl.md
Name: dcache_mem_ctrl

Overview:
Parametrised successor to the serialising dcache miss controller. It sits between the dcache/LSQ and the memory bus. Writeback, write-miss and read-miss requests are queued in a single in-order request FIFO and issued one per cycle. Loads are tracked in an MSHR file so that out-of-order memory tag responses are matched. Adds valid/ready backpressure, multiple outstanding loads, and squash-without-loss on exceptions.

Parameters:
LSQSZ, 16, LSQ entries; width of one-hot grant/feedback vectors
ADDR_W, 16, byte address width; line index = addr[IDX_W+2:3], tag = addr[ADDR_W-1:IDX_W+3]
IDX_W, 5, dcache index width
Q_DEPTH, 8, request FIFO entries (power of 2, >=4)
NUM_MSHR, 4, outstanding loads (>=1, <=15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0)
except  in  1  squash all pending loads
wb_valid  in  1  dirty-line writeback request
wb_ready  out  1  writeback accepted when valid&ready
wb_addr  in  ADDR_W  writeback address
wb_data  in  64  writeback data (always DOUBLE)
wr_valid  in  1  write-miss store request
wr_ready  out  1  store accepted
wr_addr  in  ADDR_W  store address
wr_data  in  64  store data
wr_size  in  2  BYTE/HALF/WORD/DOUBLE
rd_valid  in  1  read-miss request
rd_ready  out  1  load accepted
rd_addr  in  ADDR_W  load address
rd_size  in  2  requested size (memory always asked for DOUBLE)
rd_signed  in  1  sign-extend result (used only with optional feature)
rd_gnt  in  LSQSZ  one-hot LSQ requester
mem2proc_response  in  4  0 = not accepted, else transaction tag
mem2proc_data  in  64  load return data
mem2proc_tag  in  4  0 = none, else completing tag
Dmem_command  out  2  BUS_NONE/BUS_LOAD/BUS_STORE
Dmem_addr  out  ADDR_W  bus address
Dmem_size  out  2  bus size
Dmem_data  out  64  store data
mem_feedback  out  LSQSZ  one-hot LSQ completion
mem_data  out  32  extracted load result
mem_wr_en  out  1  dcache fill strobe
mem_wr_idx  out  IDX_W  fill index
mem_wr_tag  out  ADDR_W-IDX_W-3  fill tag
mem_wr_data  out  64  fill data
q_count  out  $clog2(Q_DEPTH)+1  FIFO occupancy
mshr_busy  out  NUM_MSHR  MSHR valid bits

Behaviour:
- Reset (reset==0 at clock edge): FIFO empty and MSHRs invalid. Outputs read Dmem_command=BUS_NONE, Dmem_addr/size/data=0, mem_feedback=0, mem_data=0, mem_wr_en=0, q_count=0, mshr_busy=0. wb/wr/rd_ready are 1 the first cycle after reset.
- Enqueue: free = Q_DEPTH - q_count, computed from registered state. wb_ready = free>=1. wr_ready = free >= 1+wb_valid. rd_ready = free >= 1+wb_valid+wr_valid. Accepted requests enter the FIFO in order wb, wr, rd. Up to 3 entries per cycle. The ready signals do not depend on the same-cycle pop.
- Issue: the FIFO head drives the bus combinationally. wb/wr use BUS_STORE with the entry size; wb is DOUBLE. rd uses BUS_LOAD, DOUBLE, with Dmem_data=0. A load head is presented only if an MSHR is free; otherwise the bus shows BUS_NONE and the FIFO stalls.
- Pop and accept: the head is popped on the cycle mem2proc_response != 0.
  - A store then retires.
  - A load allocates the lowest free MSHR with {addr, size, signed, gnt, tag=response}.
- Completion: mem2proc_tag != 0 matching a valid MSHR tag produces a same-cycle (combinational) result:
  - mem_wr_en=1, mem_wr_data=mem2proc_data, idx/tag taken from the MSHR addr.
  - mem_feedback = MSHR gnt, unless squashed.
  - mem_data = (data >> 8*addr[2:0]) masked to size, zero-extended, truncated to 32.
  - The MSHR frees at the clock edge.
  - Responses may arrive in any order.
  - Alloc and free in the same cycle are legal; a freed slot becomes allocatable the next cycle.
  - A non-matching tag is ignored.
- except: at the clock edge, all load entries in the FIFO are converted to no-ops (popped without a bus command) and every valid MSHR sets squashed. A squashed MSHR still fills the dcache on completion, with mem_feedback=0 and mem_data=0. A load accepted in the same cycle as except is squashed. Stores and writebacks are unaffected. Pointer wrap-around uses modulo-Q_DEPTH binary pointers. Full is distinguished from empty by q_count.

Optional Feature:
DCACHE_MEM_CTRL_SIGNEXT_EN: when defined, mem_data sign-extends BYTE/HALF results from bit 7/15 if the MSHR signed bit is set. When undefined, rd_signed is ignored and results are always zero-extended.

Test Plan:
- Reset release, then wb 0x0100 + wr 0x0208 (HALF, data 0xBEEF) + rd 0x0310 (WORD, gnt=0x0004) in one cycle, response=1,2,3 -> bus shows STORE 0x0100 DOUBLE, then STORE 0x0208 HALF, then LOAD 0x0310 DOUBLE. q_count goes 3,2,1,0. mshr_busy=0001.
- Loads A (tag 5, gnt 0x0001) and B (tag 6, gnt 0x0002) outstanding; tag 6 returns before tag 5 -> feedback 0x0002, then 0x0001. Each fill shows the correct idx/tag.
- Fill all NUM_MSHR=4, then queue a fifth load -> Dmem_command=BUS_NONE and the FIFO holds until a completion. The load issues the cycle after the free.
- Fill the FIFO to 8 -> all readys 0. Pop one with wb_valid=1 -> wr_ready=0. Response=0 for 3 cycles -> head held, no pop.
- except with 2 loads queued and 1 in an MSHR -> the queued loads are never issued. The MSHR return with data 0x1122334455667788 gives mem_wr_en=1, feedback=0, mem_data=0.
- rd 0x0406 HALF, data 0x8001_0000_0000_0000 -> mem_data=0x00008001; with the macro and rd_signed=1 -> 0xFFFF8001.
